// File: rtl/bus_write_decoder_if.sv
// CPU store bus plus UART TX stream and decoder status outputs.
// The leds signal exists only when BUS_WRITE_LED_EN is defined.
interface bus_write_decoder_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        write;
  logic        ram_we;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_full;
  logic        tx_ovf;
  logic        gauss_start;
  logic        bad_wr;
`ifdef BUS_WRITE_LED_EN
  logic [15:0] leds;
`endif

  modport master (
    output addr, wdata, write, tx_ready,
    input  ram_we, tx_data, tx_valid, tx_full, tx_ovf, gauss_start, bad_wr
`ifdef BUS_WRITE_LED_EN
    , input leds
`endif
  );

  modport slave (
    input  addr, wdata, write, tx_ready,
    output ram_we, tx_data, tx_valid, tx_full, tx_ovf, gauss_start, bad_wr
`ifdef BUS_WRITE_LED_EN
    , output leds
`endif
  );
endinterface

// File: rtl/bus_write_decoder.sv
// CPU store decoder: RAM write enable, UART TX byte FIFO, gauss start pulse, bad-write pulse.
// Optional LED register compiled in with BUS_WRITE_LED_EN; otherwise the LED address is unmapped.
module bus_write_decoder #(
  parameter int FIFO_DEPTH = 4
) (
  input logic              clk,
  input logic              rst_n,
  bus_write_decoder_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [31:0] RAM_LO    = 32'h0000_1000;
  localparam logic [31:0] RAM_HI    = 32'h0000_13FF;
  localparam logic [31:0] UART_DATA = 32'h0000_2000;
  localparam logic [31:0] UART_CTRL = 32'h0000_2004;
  localparam logic [31:0] LED_ADDR  = 32'h0000_2400;
  localparam logic [31:0] GAUSS     = 32'h0000_2800;

  logic hit_ram, hit_data, hit_ctrl, hit_led, hit_gauss, unmapped;

  always_comb begin
    hit_ram   = (bus.addr >= RAM_LO) && (bus.addr <= RAM_HI);
    hit_data  = (bus.addr == UART_DATA);
    hit_ctrl  = (bus.addr == UART_CTRL);
    hit_gauss = (bus.addr == GAUSS);
`ifdef BUS_WRITE_LED_EN
    hit_led   = (bus.addr == LED_ADDR);
`else
    hit_led   = 1'b0;
`endif
    unmapped  = !(hit_ram || hit_data || hit_ctrl || hit_gauss || hit_led);
  end

  assign bus.ram_we = bus.write && hit_ram;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic          full, valid, push, pop, ovf_set, flush, ovf_clr;

  // Full is taken from the current count, so a pop in the same cycle cannot make room.
  assign full    = (count == CW'(FIFO_DEPTH));
  assign valid   = (count != '0);
  assign push    = bus.write && hit_data && !full;
  assign ovf_set = bus.write && hit_data && full;
  assign pop     = valid && bus.tx_ready;
  assign flush   = bus.write && hit_ctrl && bus.wdata[0];
  assign ovf_clr = bus.write && hit_ctrl && bus.wdata[1];

  assign bus.tx_valid = valid;
  assign bus.tx_full  = full;
  assign bus.tx_data  = mem[rptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= bus.wdata[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.tx_ovf      <= 1'b0;
      bus.gauss_start <= 1'b0;
      bus.bad_wr      <= 1'b0;
    end else begin
      if (ovf_set)      bus.tx_ovf <= 1'b1;
      else if (ovf_clr) bus.tx_ovf <= 1'b0;
      bus.gauss_start <= bus.write && hit_gauss && bus.wdata[0];
      bus.bad_wr      <= bus.write && unmapped;
    end
  end

`ifdef BUS_WRITE_LED_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.leds <= 16'h0000;
    end else if (bus.write && hit_led) begin
      bus.leds <= bus.wdata[15:0];
    end
  end
`endif
endmodule

// File: tb/tb_bus_write_decoder.sv
// Directed bench for bus_write_decoder; TX bytes are checked against a scoreboard queue.
module tb_bus_write_decoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   xfers = 0;
  int   n;
  logic [7:0] q[$];

  bus_write_decoder_if bif();

  bus_write_decoder #(.FIFO_DEPTH(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bif.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Transfers are sampled mid-cycle and compared against the scoreboard head.
  task automatic cycle();
    logic [7:0] exp;
    @(negedge clk);
    if (bif.tx_valid && bif.tx_ready) begin
      xfers++;
      exp = 8'hxx;
      if (q.size() > 0) exp = q.pop_front();
      check("tx_data", {24'h0, bif.tx_data}, {24'h0, exp});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    bif.write = 1'b1;
    bif.addr  = a;
    bif.wdata = d;
    cycle();
    bif.write = 1'b0;
  endtask

  task automatic uart_push(input logic [7:0] b, input bit accept);
    if (accept) q.push_back(b);
    bus_wr(32'h2000, {24'h0, b});
  endtask

  task automatic drain(output int cnt);
    int start;
    start = xfers;
    bif.tx_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (!bif.tx_valid) break;
      cycle();
    end
    bif.tx_ready = 1'b0;
    check("drain_done", {31'h0, bif.tx_valid}, 32'h0);
    cnt = xfers - start;
  endtask

  initial begin
    bif.addr = '0; bif.wdata = '0; bif.write = 1'b0; bif.tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx_valid", {31'h0, bif.tx_valid}, 32'h0);
    check("rst_tx_full",  {31'h0, bif.tx_full},  32'h0);
    check("rst_tx_ovf",   {31'h0, bif.tx_ovf},   32'h0);
    check("rst_gauss",    {31'h0, bif.gauss_start}, 32'h0);
    check("rst_bad_wr",   {31'h0, bif.bad_wr},   32'h0);
    rst_n = 1'b1;
    cycle();

    // RAM decode, combinational
    bif.write = 1'b1; bif.addr = 32'h1004; #1;
    check("ram_we_1004", {31'h0, bif.ram_we}, 32'h1);
    bif.addr = 32'h13FF; #1;
    check("ram_we_13ff", {31'h0, bif.ram_we}, 32'h1);
    bif.addr = 32'h0FFF; #1;
    check("ram_we_0fff", {31'h0, bif.ram_we}, 32'h0);
    bif.write = 1'b0; bif.addr = 32'h1004; #1;
    check("ram_we_nowr", {31'h0, bif.ram_we}, 32'h0);
    bif.write = 1'b1; bif.addr = 32'h1400; #1;
    check("ram_we_1400", {31'h0, bif.ram_we}, 32'h0);
    cycle();
    bif.write = 1'b0;
    check("bad_wr_1400", {31'h0, bif.bad_wr}, 32'h1);
    check("bad_no_push", {31'h0, bif.tx_valid}, 32'h0);
    cycle();
    check("bad_wr_end",  {31'h0, bif.bad_wr}, 32'h0);

    // write=0 to UART_DATA does nothing
    bif.addr = 32'h2000; bif.wdata = 32'h77;
    cycle();
    check("nowrite_push", {31'h0, bif.tx_valid}, 32'h0);

    // In-order transmit
    uart_push(8'h41, 1'b1);
    check("tx_valid_1st", {31'h0, bif.tx_valid}, 32'h1);
    check("tx_head_41",   {24'h0, bif.tx_data}, 32'h41);
    uart_push(8'h42, 1'b1);
    uart_push(8'h43, 1'b1);
    drain(n);
    check("abc_count", n, 32'd3);

    // Overflow on fifth push
    uart_push(8'h10, 1'b1);
    uart_push(8'h11, 1'b1);
    uart_push(8'h12, 1'b1);
    check("full_at_3", {31'h0, bif.tx_full}, 32'h0);
    uart_push(8'h13, 1'b1);
    check("full_at_4", {31'h0, bif.tx_full}, 32'h1);
    check("ovf_at_4",  {31'h0, bif.tx_ovf},  32'h0);
    uart_push(8'h14, 1'b0);
    check("ovf_at_5",  {31'h0, bif.tx_ovf},  32'h1);
    check("full_at_5", {31'h0, bif.tx_full}, 32'h1);
    drain(n);
    check("ovf_drain_count", n, 32'd4);
    bus_wr(32'h2004, 32'h2);
    check("ovf_clear", {31'h0, bif.tx_ovf}, 32'h0);

    // Push and pop together on a full FIFO
    uart_push(8'hA0, 1'b1);
    uart_push(8'hA1, 1'b1);
    uart_push(8'hA2, 1'b1);
    uart_push(8'hA3, 1'b1);
    bif.tx_ready = 1'b1;
    uart_push(8'h99, 1'b0);
    bif.tx_ready = 1'b0;
    check("fullpp_ovf",  {31'h0, bif.tx_ovf},  32'h1);
    check("fullpp_full", {31'h0, bif.tx_full}, 32'h0);
    bus_wr(32'h2004, 32'h2);
    check("fullpp_clr",  {31'h0, bif.tx_ovf},  32'h0);
    // Push and pop together on a partly filled FIFO keeps count at 3
    bif.tx_ready = 1'b1;
    uart_push(8'hB0, 1'b1);
    bif.tx_ready = 1'b0;
    check("pp_not_full", {31'h0, bif.tx_full}, 32'h0);
    uart_push(8'hC0, 1'b1);
    check("pp_then_full", {31'h0, bif.tx_full}, 32'h1);
    drain(n);
    check("pp_drain_count", n, 32'd4);

    // Flush
    uart_push(8'h21, 1'b1);
    uart_push(8'h22, 1'b1);
    bus_wr(32'h2004, 32'h1);
    q.delete();
    check("flush_valid", {31'h0, bif.tx_valid}, 32'h0);
    check("flush_full",  {31'h0, bif.tx_full},  32'h0);

    // Gauss pulses
    bif.write = 1'b1; bif.addr = 32'h2800; bif.wdata = 32'h1;
    cycle();
    check("gauss_p1", {31'h0, bif.gauss_start}, 32'h1);
    cycle();
    check("gauss_p2", {31'h0, bif.gauss_start}, 32'h1);
    bif.wdata = 32'h0;
    cycle();
    check("gauss_w0", {31'h0, bif.gauss_start}, 32'h0);
    check("gauss_nobad", {31'h0, bif.bad_wr}, 32'h0);
    bif.write = 1'b0;
    cycle();
    check("gauss_idle", {31'h0, bif.gauss_start}, 32'h0);

    // Reset with bytes queued
    uart_push(8'h31, 1'b1);
    uart_push(8'h32, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", {31'h0, bif.tx_valid}, 32'h0);
    check("midrst_full",  {31'h0, bif.tx_full},  32'h0);
    q.delete();
    cycle();
    rst_n = 1'b1;
    uart_push(8'h55, 1'b1);
    check("postrst_head", {24'h0, bif.tx_data}, 32'h55);
    drain(n);
    check("postrst_count", n, 32'd1);

`ifdef BUS_WRITE_LED_EN
    check("leds_rst", {16'h0, bif.leds}, 32'h0);
    bus_wr(32'h2400, 32'h1234_ABCD);
    check("leds_load", {16'h0, bif.leds}, 32'hABCD);
    check("leds_nobad", {31'h0, bif.bad_wr}, 32'h0);
`else
    bus_wr(32'h2400, 32'h1234_ABCD);
    check("led_unmapped", {31'h0, bif.bad_wr}, 32'h1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
